// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_idx_i, wrapping.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_idx_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    // Scan last+1 .. last+NUM_REQ so last_idx_i itself has lowest priority.
    always_comb begin
        logic [IDX_W-1:0] pos;
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        pos      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = IDX_W'((32'(last_idx_i) + k) % NUM_REQ);
            if (!valid_o && req_i[pos]) begin
                valid_o       = 1'b1;
                idx_o         = pos;
                onehot_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// with bounded bursts, full-flag back-pressure and a write-error counter.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BURST   = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    input  logic                     fifo_full_i,
    input  logic                     fifo_wr_error_i,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);

    localparam int unsigned BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic               beat;
    logic               release_grant;
    logic [IDX_W-1:0]   pick_last;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    // While granted, rotation starts after the current holder.
    assign pick_last = (state_q == ST_GRANT) ? gidx_q : last_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i      (req_i),
        .last_idx_i (pick_last),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx),
        .onehot_o   (pick_onehot)
    );

    // Write-port datapath; reset and full both suppress any beat.
    always_comb begin
        beat          = (state_q == ST_GRANT) && req_i[gidx_q] && !fifo_full_i && !rst_i;
        ack_o         = beat ? gnt_q : '0;
        fifo_wr_en_o  = beat;
        fifo_wdata_o  = (state_q == ST_GRANT) ? wdata_i[32'(gidx_q)*WIDTH +: WIDTH] : '0;
        release_grant = (state_q == ST_GRANT) &&
                        (!req_i[gidx_q] || (beat && (beat_q == BEAT_LAST)));
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot;
                    gidx_d  = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    last_d = gidx_q;
                    beat_d = '0;
                    if (pick_valid) begin
                        gnt_d  = pick_onehot;
                        gidx_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (fifo_wr_error_i && (err_q != ERR_CNT_MAX)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, rotation, stalls, drops, reset, error counter.
module tb_fifo_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  ack_o;
    logic [3:0]  gnt_o;
    logic        fifo_wr_en_o;
    logic [7:0]  fifo_wdata_o;
    logic        fifo_full_i = 1'b0;
    logic        fifo_wr_error_i = 1'b0;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fifo_wr_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (8),
        .BURST   (4),
        .IDX_W   (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .wdata_i         (wdata_i),
        .ack_o           (ack_o),
        .gnt_o           (gnt_o),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .fifo_wdata_o    (fifo_wdata_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_wr_error_i (fifo_wr_error_i),
        .err_cnt_o       (err_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, then let outputs settle.
    task automatic drive(input logic [3:0] req, input logic full);
        @(negedge clk_i);
        req_i       = req;
        fifo_full_i = full;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i           = 1'b1;
        req_i           = 4'b1111;
        fifo_full_i     = 1'b0;
        fifo_wr_error_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'h0);
        chk("rst_err", 32'(err_cnt_o), 32'h0);
        rst_i = 1'b0;
        req_i = 4'b0000;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        int         idx;

        // 1: single requester, 6 beats, burst re-grant without bubble
        do_reset();
        wdata_i = 32'h0000_00A0;
        drive(4'b0001, 1'b0);
        chk("t1_idle_gnt", 32'(gnt_o), 32'h0);
        chk("t1_idle_wr_en", 32'(fifo_wr_en_o), 32'h0);
        chk("t1_idle_wdata", 32'(fifo_wdata_o), 32'h0);
        for (int b = 0; b < 6; b++) begin
            wdata_i = {24'h0, 8'(8'hA0 + b)};
            drive(4'b0001, 1'b0);
            chk($sformatf("t1_gnt_b%0d", b), 32'(gnt_o), 32'h1);
            chk($sformatf("t1_ack_b%0d", b), 32'(ack_o), 32'h1);
            chk($sformatf("t1_wr_en_b%0d", b), 32'(fifo_wr_en_o), 32'h1);
            chk($sformatf("t1_wdata_b%0d", b), 32'(fifo_wdata_o), 32'(8'hA0 + b));
        end
        drive(4'b0000, 1'b0);
        chk("t1_drop_wr_en", 32'(fifo_wr_en_o), 32'h0);
        chk("t1_drop_gnt_held", 32'(gnt_o), 32'h1);
        drive(4'b0000, 1'b0);
        chk("t1_idle_after", 32'(gnt_o), 32'h0);

        // 2: all requesting, rotation 0,1,2,3,0,1 in 4-beat bursts
        do_reset();
        wdata_i = 32'h3322_1100;
        drive(4'b1111, 1'b0);
        chk("t2_first_wr_en", 32'(fifo_wr_en_o), 32'h0);
        for (int c = 0; c < 26; c++) begin
            idx     = (c / 4) % 4;
            exp_gnt = 4'b0001 << idx;
            drive(4'b1111, 1'b0);
            chk($sformatf("t2_gnt_c%0d", c), 32'(gnt_o), 32'(exp_gnt));
            chk($sformatf("t2_ack_c%0d", c), 32'(ack_o), 32'(exp_gnt));
            chk($sformatf("t2_wr_en_c%0d", c), 32'(fifo_wr_en_o), 32'h1);
            chk($sformatf("t2_wdata_c%0d", c), 32'(fifo_wdata_o), 32'(8'h11 * idx));
        end

        // 3: req2 stalled by full after 2 beats, then exactly 2 more beats
        for (int s = 0; s < 5; s++) begin
            drive(4'b1111, 1'b1);
            chk($sformatf("t3_full_wr_en_%0d", s), 32'(fifo_wr_en_o), 32'h0);
            chk($sformatf("t3_full_ack_%0d", s), 32'(ack_o), 32'h0);
            chk($sformatf("t3_full_gnt_%0d", s), 32'(gnt_o), 32'h4);
        end
        for (int s = 0; s < 2; s++) begin
            drive(4'b1111, 1'b0);
            chk($sformatf("t3_resume_gnt_%0d", s), 32'(gnt_o), 32'h4);
            chk($sformatf("t3_resume_wr_en_%0d", s), 32'(fifo_wr_en_o), 32'h1);
        end
        drive(4'b1111, 1'b0);
        chk("t3_rotate_gnt", 32'(gnt_o), 32'h8);
        chk("t3_rotate_wdata", 32'(fifo_wdata_o), 32'h33);

        // 4: req1 drops after one beat while req3 waits
        do_reset();
        wdata_i = 32'h3322_1100;
        drive(4'b0010, 1'b0);
        chk("t4_idle_gnt", 32'(gnt_o), 32'h0);
        drive(4'b1010, 1'b0);
        chk("t4_beat_gnt", 32'(gnt_o), 32'h2);
        chk("t4_beat_ack", 32'(ack_o), 32'h2);
        drive(4'b1000, 1'b0);
        chk("t4_drop_ack", 32'(ack_o), 32'h0);
        chk("t4_drop_wr_en", 32'(fifo_wr_en_o), 32'h0);
        drive(4'b1000, 1'b0);
        chk("t4_next_gnt", 32'(gnt_o), 32'h8);
        chk("t4_next_ack", 32'(ack_o), 32'h8);
        chk("t4_next_wdata", 32'(fifo_wdata_o), 32'h33);

        // 5: reset mid-burst of req0
        do_reset();
        drive(4'b1111, 1'b0);
        drive(4'b1111, 1'b0);
        chk("t5_gnt0", 32'(gnt_o), 32'h1);
        drive(4'b1111, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t5_rst_ack", 32'(ack_o), 32'h0);
        chk("t5_rst_wr_en", 32'(fifo_wr_en_o), 32'h0);
        @(negedge clk_i);
        #1;
        chk("t5_rst_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("t5_post_idle_gnt", 32'(gnt_o), 32'h0);
        drive(4'b1111, 1'b0);
        chk("t5_post_gnt", 32'(gnt_o), 32'h1);
        chk("t5_post_ack", 32'(ack_o), 32'h1);

        // 6: error counter counts, saturates, clears on reset
        do_reset();
        @(negedge clk_i);
        fifo_wr_error_i = 1'b1;
        repeat (3) @(negedge clk_i);
        fifo_wr_error_i = 1'b0;
        #1;
        chk("t6_err3", 32'(err_cnt_o), 32'd3);
        @(negedge clk_i);
        fifo_wr_error_i = 1'b1;
        repeat (300) @(negedge clk_i);
        fifo_wr_error_i = 1'b0;
        #1;
        chk("t6_err_sat", 32'(err_cnt_o), 32'd255);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
